lfsr4_checker: RTL and testbench
================================

Name: lfsr4_checker

Overview:
- Downstream consumer of the team's 4-bit pseudo-random sequence register.
- Samples the 4-bit word stream, predicts each next word with the same recurrence, and locks onto the sequence.
- Once locked, counts prediction errors with saturation and drops lock after repeated consecutive errors.
- Used as the self-check stage in bring-up and test benches for the sequence generator.

Parameters:
LOCK_CNT, 3, consecutive correct predictions needed to enter LOCKED (legal range 1..15)
LOSS_CNT, 2, consecutive mispredictions in LOCKED that force return to SEARCH (legal range 1..15)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-low
d_in  input  4  sample word from the generator, bit 0 = stage 0
d_valid  input  1  d_in is valid this cycle; the sample is taken on this edge
clr_err  input  1  synchronous clear of err_cnt
locked  output  1  high while the FSM is in LOCKED
err_pulse  output  1  one-cycle pulse on each counted error
err_cnt  output  ERR_W  saturating error count
expected  output  4  predicted value of the next valid sample

Behaviour:
- Recurrence: next(x) = {x[2]^x[3], x[1]^x[3], x[0]^x[3], x[3]}, bit order [3:0].
- Generator cycle from reset: 1111 -> 0001 -> 0010 -> 0100 -> 1000 -> 1111 (period 5). The value 0000 is the stuck state and is always illegal.
- Asynchronous reset (rst low) clears state immediately, not on a clock edge:
  - state = SEARCH, has_prev = 0, good_cnt = 0, bad_cnt = 0.
  - locked = 0, err_pulse = 0, err_cnt = 0, expected = 4'b1111.
- All outputs are registered. Each output reflects a valid sample on the same edge that samples it (latency of 1 edge). The block does nothing on cycles with d_valid low.
- err_pulse defaults to 0 every cycle.
- SEARCH, valid sample v:
  - v == 0000: has_prev = 0, good_cnt = 0.
  - has_prev == 0: seed. expected = next(v), has_prev = 1, no compare.
  - v == expected: good_cnt++, expected = next(v). When good_cnt reaches LOCK_CNT: go to LOCKED, locked = 1, bad_cnt = 0.
  - v != expected: good_cnt = 0, expected = next(v) (reseed).
  - No errors are counted while in SEARCH.
- LOCKED, valid sample v:
  - The prediction free-runs: expected = next(expected) on every valid sample, whether v matches or not, so an isolated corrupted word does not cascade into further errors.
  - Match: bad_cnt = 0.
  - Mismatch (including 0000): err_pulse = 1, err_cnt = min(err_cnt + 1, 2^ERR_W - 1), bad_cnt++. When bad_cnt reaches LOSS_CNT: go to SEARCH, locked = 0, has_prev = 0, good_cnt = 0.
- clr_err is synchronous and independent of d_valid.
  - If it coincides with an error, clr wins: err_cnt = 0, but err_pulse still asserts.
- err_cnt is kept across loss and relock; only rst or clr_err clear it.

Test Plan:
- Reset, then d_valid=1 every cycle with d_in = 1111,0001,0010,0100 -> locked rises on the edge that samples 0100 (4th valid edge); err_cnt = 0; expected = 1000.
- Locked, feed 1000,1111,0110(corrupt),0010,0100 -> a single err_pulse on the 0110 edge; err_cnt = 1; locked stays 1. (0110 replaces the expected 0001, so the prediction continues 0010,0100 and both match.)
- Locked, feed two consecutive wrong words 0101,0101 -> err_cnt += 2; locked falls on the 2nd edge. Resuming a correct stream relocks after 1 seed plus 3 matches, and err_cnt is unchanged.
- SEARCH, feed 0000 then 0001,0010,0100,1000 -> 0000 clears the seed; locked rises on the 1000 edge; no err_pulse at any point.
- ERR_W=2, locked, 5 consecutive errors with LOSS_CNT=15 -> err_cnt = 1,2,3,3,3 (saturates at 3). clr_err asserted on an error cycle -> err_cnt = 0 and err_pulse = 1.
- Drop rst mid-stream between clock edges while locked -> locked = 0, err_cnt = 0, expected = 1111 immediately, without waiting for a clock edge; behaviour after rst release is identical to the first scenario.

Source files
------------

// File: rtl/lfsr4_checker.sv
// Sequence checker for the 4-bit pseudo-random word stream.
// It predicts each next word with the generator's recurrence and locks after a
// run of correct predictions. While locked, it counts mispredictions with
// saturation, and it drops lock after a run of consecutive misses.
module lfsr4_checker #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       d_in,
  input  logic             d_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       expected
);

  typedef enum logic {StSearch, StLocked} state_t;

  localparam logic [ERR_W-1:0] ErrOne  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ErrMax  = '1;
  localparam logic [3:0]       LockTgt = 4'(LOCK_CNT);
  localparam logic [3:0]       LossTgt = 4'(LOSS_CNT);

  state_t     state_q;
  logic       has_prev_q;
  logic [3:0] good_cnt_q;
  logic [3:0] bad_cnt_q;

  // Same recurrence as the generator, bit order [3:0].
  function automatic logic [3:0] lfsr_next(input logic [3:0] x);
    return {x[2] ^ x[3], x[1] ^ x[3], x[0] ^ x[3], x[3]};
  endfunction

  // Single FSM register block; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StSearch;
      has_prev_q <= 1'b0;
      good_cnt_q <= 4'd0;
      bad_cnt_q  <= 4'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      expected   <= 4'b1111;
    end else begin
      err_pulse <= 1'b0;
      if (d_valid) begin
        unique case (state_q)
          StSearch: begin
            if (d_in == 4'b0000) begin
              // Stuck word: discard the seed and start over.
              has_prev_q <= 1'b0;
              good_cnt_q <= 4'd0;
            end else if (!has_prev_q) begin
              expected   <= lfsr_next(d_in);
              has_prev_q <= 1'b1;
            end else if (d_in == expected) begin
              expected <= lfsr_next(d_in);
              if (good_cnt_q + 4'd1 == LockTgt) begin
                state_q    <= StLocked;
                locked     <= 1'b1;
                bad_cnt_q  <= 4'd0;
                good_cnt_q <= 4'd0;
              end else begin
                good_cnt_q <= good_cnt_q + 4'd1;
              end
            end else begin
              // Reseed from the observed word.
              good_cnt_q <= 4'd0;
              expected   <= lfsr_next(d_in);
            end
          end
          StLocked: begin
            // Free-running prediction so one corrupt word costs one error only.
            expected <= lfsr_next(expected);
            if (d_in == expected) begin
              bad_cnt_q <= 4'd0;
            end else begin
              err_pulse <= 1'b1;
              if (err_cnt != ErrMax) begin
                err_cnt <= err_cnt + ErrOne;
              end
              if (bad_cnt_q + 4'd1 == LossTgt) begin
                state_q    <= StSearch;
                locked     <= 1'b0;
                has_prev_q <= 1'b0;
                good_cnt_q <= 4'd0;
                bad_cnt_q  <= 4'd0;
              end else begin
                bad_cnt_q <= bad_cnt_q + 4'd1;
              end
            end
          end
          default: state_q <= StSearch;
        endcase
      end
      // Clear takes priority over a same-cycle increment.
      if (clr_err) begin
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr4_checker.sv
// Scoreboard bench: the drivers queue hand-computed responses, and the monitors pop
// and compare them on every edge that samples d_valid or clr_err.
module tb_lfsr4_checker;

  typedef struct packed {
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic [3:0] ex;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic [3:0] d_in_a = 4'd0, d_in_b = 4'd0;
  logic       d_valid_a = 1'b0, d_valid_b = 1'b0;
  logic       clr_a = 1'b0, clr_b = 1'b0;
  logic       locked_a, locked_b, err_pulse_a, err_pulse_b;
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;
  logic [3:0] expected_a, expected_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  int   n_a = 0, n_b = 0;
  logic fire_a, fire_b;

  lfsr4_checker dut_a (
    .clk      (clk),
    .rst      (rst_n),
    .d_in     (d_in_a),
    .d_valid  (d_valid_a),
    .clr_err  (clr_a),
    .locked   (locked_a),
    .err_pulse(err_pulse_a),
    .err_cnt  (err_cnt_a),
    .expected (expected_a)
  );

  lfsr4_checker #(
    .LOCK_CNT(3),
    .LOSS_CNT(15),
    .ERR_W   (2)
  ) dut_b (
    .clk      (clk),
    .rst      (rst_n),
    .d_in     (d_in_b),
    .d_valid  (d_valid_b),
    .clr_err  (clr_b),
    .locked   (locked_b),
    .err_pulse(err_pulse_b),
    .err_cnt  (err_cnt_b),
    .expected (expected_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic send_a(input logic [3:0] v, input logic vld, input logic clr,
                        input logic lk, input logic ep, input logic [7:0] ec,
                        input logic [3:0] ex);
    @(negedge clk);
    d_in_a = v; d_valid_a = vld; clr_a = clr;
    if (vld || clr) q_a.push_back({lk, ep, ec, ex});
  endtask

  task automatic send_b(input logic [3:0] v, input logic vld, input logic clr,
                        input logic lk, input logic ep, input logic [7:0] ec,
                        input logic [3:0] ex);
    @(negedge clk);
    d_in_b = v; d_valid_b = vld; clr_b = clr;
    if (vld || clr) q_b.push_back({lk, ep, ec, ex});
  endtask

  task automatic idle_ab();
    @(negedge clk);
    d_valid_a = 1'b0; clr_a = 1'b0; d_valid_b = 1'b0; clr_b = 1'b0;
  endtask

  // Scenario 1 stream, reused after the mid-stream reset.
  task automatic lock_a();
    send_a(4'b1111, 1, 0, 0, 0, 8'd0, 4'b0001);
    send_a(4'b0001, 1, 0, 0, 0, 8'd0, 4'b0010);
    send_a(4'b0010, 1, 0, 0, 0, 8'd0, 4'b0100);
    send_a(4'b0100, 1, 0, 1, 0, 8'd0, 4'b1000);
  endtask

  // Monitor for DUT A.
  always @(posedge clk) begin
    fire_a = d_valid_a | clr_a;
    #1;
    if (fire_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got output with empty queue, want none");
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk($sformatf("a#%0d", n_a), 16'({locked_a, err_pulse_a, err_cnt_a, expected_a}),
            16'(e));
        n_a++;
      end
    end
  end

  // Monitor for DUT B.
  always @(posedge clk) begin
    fire_b = d_valid_b | clr_b;
    #1;
    if (fire_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got output with empty queue, want none");
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk($sformatf("b#%0d", n_b),
            16'({locked_b, err_pulse_b, 6'd0, err_cnt_b, expected_b}), 16'(e));
        n_b++;
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_locked", 16'(locked_a), 16'd0);
    chk("rst_pulse", 16'(err_pulse_a), 16'd0);
    chk("rst_errcnt", 16'(err_cnt_a), 16'd0);
    chk("rst_expected", 16'(expected_a), 16'hf);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock on the fourth valid sample.
    lock_a();
    // One corrupt word costs exactly one error.
    send_a(4'b1000, 1, 0, 1, 0, 8'd0, 4'b1111);
    send_a(4'b1111, 1, 0, 1, 0, 8'd0, 4'b0001);
    send_a(4'b0110, 1, 0, 1, 1, 8'd1, 4'b0010);
    send_a(4'b0010, 1, 0, 1, 0, 8'd1, 4'b0100);
    send_a(4'b0100, 1, 0, 1, 0, 8'd1, 4'b1000);
    // Two consecutive misses drop lock.
    send_a(4'b0101, 1, 0, 1, 1, 8'd2, 4'b1111);
    send_a(4'b0101, 1, 0, 0, 1, 8'd3, 4'b0001);
    // Relock: one seed plus three matches.
    send_a(4'b0001, 1, 0, 0, 0, 8'd3, 4'b0010);
    send_a(4'b0010, 1, 0, 0, 0, 8'd3, 4'b0100);
    send_a(4'b0100, 1, 0, 0, 0, 8'd3, 4'b1000);
    send_a(4'b1000, 1, 0, 1, 0, 8'd3, 4'b1111);
    // Lose lock again, then check that 0000 clears the seed in SEARCH.
    send_a(4'b0101, 1, 0, 1, 1, 8'd4, 4'b0001);
    send_a(4'b0101, 1, 0, 0, 1, 8'd5, 4'b0010);
    send_a(4'b0000, 1, 0, 0, 0, 8'd5, 4'b0010);
    send_a(4'b0001, 1, 0, 0, 0, 8'd5, 4'b0010);
    send_a(4'b0010, 1, 0, 0, 0, 8'd5, 4'b0100);
    send_a(4'b0100, 1, 0, 0, 0, 8'd5, 4'b1000);
    send_a(4'b1000, 1, 0, 1, 0, 8'd5, 4'b1111);
    // An invalid cycle must not advance anything.
    send_a(4'b0101, 0, 0, 0, 0, 8'd0, 4'b0000);
    send_a(4'b1111, 1, 0, 1, 0, 8'd5, 4'b0001);
    idle_ab();

    // An asynchronous reset between edges takes effect immediately.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_locked", 16'(locked_a), 16'd0);
    chk("arst_errcnt", 16'(err_cnt_a), 16'd0);
    chk("arst_expected", 16'(expected_a), 16'hf);
    @(negedge clk);
    rst_n = 1'b1;
    lock_a();
    idle_ab();

    // ERR_W=2 saturation with LOSS_CNT=15.
    send_b(4'b1111, 1, 0, 0, 0, 8'd0, 4'b0001);
    send_b(4'b0001, 1, 0, 0, 0, 8'd0, 4'b0010);
    send_b(4'b0010, 1, 0, 0, 0, 8'd0, 4'b0100);
    send_b(4'b0100, 1, 0, 1, 0, 8'd0, 4'b1000);
    send_b(4'b0101, 1, 0, 1, 1, 8'd1, 4'b1111);
    send_b(4'b0101, 1, 0, 1, 1, 8'd2, 4'b0001);
    send_b(4'b0101, 1, 0, 1, 1, 8'd3, 4'b0010);
    send_b(4'b0101, 1, 0, 1, 1, 8'd3, 4'b0100);
    send_b(4'b0101, 1, 0, 1, 1, 8'd3, 4'b1000);
    // Clear wins over a same-cycle error, but the pulse still fires.
    send_b(4'b0101, 1, 1, 1, 1, 8'd0, 4'b1111);
    send_b(4'b1111, 1, 0, 1, 0, 8'd0, 4'b0001);
    send_b(4'b0110, 1, 0, 1, 1, 8'd1, 4'b0010);
    // Clear without a valid sample.
    send_b(4'b0000, 0, 1, 1, 0, 8'd0, 4'b0010);
    idle_ab();

    repeat (3) @(negedge clk);
    chk("q_a_drained", 16'(q_a.size()), 16'd0);
    chk("q_b_drained", 16'(q_b.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
